// File: rtl/connect4_turn_ctrl.sv
// Game-flow controller for the Connect4 core: turn sequencing for 2..8 players,
// move accept/reject, win/tie handling after each move, per-turn timeout and abort.
module connect4_turn_ctrl #(
  parameter  int NUM_PLAYERS  = 2,
  parameter  int MAX_MOVES    = 42,
  parameter  int TURN_TIMEOUT = 1000,
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int MW = $clog2(MAX_MOVES + 1),
  localparam int TW = $clog2(TURN_TIMEOUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          move_valid,
  input  logic [PW-1:0] move_player,
  input  logic          move_legal,
  input  logic          chk_done,
  input  logic          chk_win,
  output logic [1:0]    state,
  output logic [PW-1:0] cur_player,
  output logic [MW-1:0] move_count,
  output logic          move_ack,
  output logic          move_nack,
  output logic          turn_timeout,
  output logic [PW-1:0] winner,
  output logic [1:0]    game_status
);
  localparam int SW = $clog2(NUM_PLAYERS + 1);

  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [MW-1:0] MOVES_FULL  = MW'(MAX_MOVES);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TURN_TIMEOUT - 1);
  localparam logic [SW-1:0] SKIP_ALL    = SW'(NUM_PLAYERS);

  localparam logic [1:0] GS_PLAY  = 2'b00;
  localparam logic [1:0] GS_WIN   = 2'b01;
  localparam logic [1:0] GS_TIE   = 2'b10;
  localparam logic [1:0] GS_ABORT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TURN  = 2'b01,
    S_CHECK = 2'b10,
    S_END   = 2'b11
  } state_t;

  state_t        state_q, state_n;
  logic [PW-1:0] player_q, player_n, next_player;
  logic [MW-1:0] count_q, count_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [SW-1:0] skip_q, skip_n, skip_inc;
  logic [PW-1:0] winner_q, winner_n;
  logic [1:0]    status_q, status_n;
  logic          ack_q, ack_n, nack_q, nack_n, to_q, to_n;
  logic          accept;

  assign next_player = (player_q == LAST_PLAYER) ? '0 : player_q + PW'(1);
  assign skip_inc    = skip_q + SW'(1);
  assign accept      = move_valid && (move_player == player_q) && move_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      player_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      skip_q   <= '0;
      winner_q <= '0;
      status_q <= GS_PLAY;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      player_q <= player_n;
      count_q  <= count_n;
      timer_q  <= timer_n;
      skip_q   <= skip_n;
      winner_q <= winner_n;
      status_q <= status_n;
      ack_q    <= ack_n;
      nack_q   <= nack_n;
      to_q     <= to_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    player_n = player_q;
    count_n  = count_q;
    timer_n  = timer_q;
    skip_n   = skip_q;
    winner_n = winner_q;
    status_n = status_q;
    ack_n    = 1'b0;
    nack_n   = 1'b0;
    to_n     = 1'b0;
    unique case (state_q)
      S_IDLE, S_END: begin
        nack_n = move_valid;
        if (start) begin
          state_n  = S_TURN;
          player_n = '0;
          count_n  = '0;
          timer_n  = '0;
          skip_n   = '0;
          winner_n = '0;
          status_n = GS_PLAY;
        end
      end
      S_TURN: begin
        // An accept in the expiry cycle takes precedence over the timeout.
        if (accept) begin
          ack_n   = 1'b1;
          count_n = count_q + MW'(1);
          skip_n  = '0;
          state_n = S_CHECK;
        end else begin
          nack_n = move_valid;
          if (timer_q == TIMER_LAST) begin
            to_n    = 1'b1;
            timer_n = '0;
            skip_n  = skip_inc;
            if (skip_inc == SKIP_ALL) begin
              state_n  = S_END;
              status_n = GS_ABORT;
            end else begin
              player_n = next_player;
            end
          end else begin
            timer_n = timer_q + TW'(1);
          end
        end
      end
      S_CHECK: begin
        nack_n = move_valid;
        if (chk_done) begin
          if (chk_win) begin
            state_n  = S_END;
            status_n = GS_WIN;
            winner_n = player_q;
          end else if (count_q == MOVES_FULL) begin
            state_n  = S_END;
            status_n = GS_TIE;
          end else begin
            state_n  = S_TURN;
            player_n = next_player;
            timer_n  = '0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign state        = state_q;
  assign cur_player   = player_q;
  assign move_count   = count_q;
  assign move_ack     = ack_q;
  assign move_nack    = nack_q;
  assign turn_timeout = to_q;
  assign winner       = winner_q;
  assign game_status  = status_q;
endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Randomized scoreboard bench for connect4_turn_ctrl: a rule-level game model
// predicts each output event, a monitor compares whenever the DUT produces one.
module tb_connect4_turn_ctrl;
  localparam int NP = 3;
  localparam int MM = 4;
  localparam int TT = 8;
  localparam int PW = 2;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset, start, move_valid, move_legal, chk_done, chk_win;
  logic [PW-1:0] move_player;
  logic [1:0]    state, game_status;
  logic [PW-1:0] cur_player, winner;
  logic [MW-1:0] move_count;
  logic          move_ack, move_nack, turn_timeout;

  connect4_turn_ctrl #(.NUM_PLAYERS(NP), .MAX_MOVES(MM), .TURN_TIMEOUT(TT)) dut (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .move_player(move_player), .move_legal(move_legal), .chk_done(chk_done),
    .chk_win(chk_win), .state(state), .cur_player(cur_player),
    .move_count(move_count), .move_ack(move_ack), .move_nack(move_nack),
    .turn_timeout(turn_timeout), .winner(winner), .game_status(game_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ack, nack, to;
    int st, pl, cnt, win, gs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  logic [1:0] last_state;

  // Reference game: phase 0 idle, 1 turn, 2 check, 3 over; elapsed counts turn cycles.
  int m_st, m_pl, m_cnt, m_elapsed, m_skips, m_win, m_gs;

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_pl = 0; m_cnt = 0; m_elapsed = 0; m_skips = 0; m_win = 0; m_gs = 0;
  endtask

  // Per-mille probabilities for each input this cycle.
  task automatic drive_cycle(input int pmv, input int pgood, input int plegal,
                             input int pdone, input int pwin, input int pstart,
                             input int prst);
    bit r, s, mv, lg, cd, cw;
    int mp, prev;
    exp_t e;
    @(posedge clk); #1;
    r  = ($urandom_range(999) < prst);
    s  = ($urandom_range(999) < pstart);
    mv = ($urandom_range(999) < pmv);
    lg = ($urandom_range(999) < plegal);
    cd = ($urandom_range(999) < pdone);
    cw = ($urandom_range(999) < pwin);
    mp = ($urandom_range(999) < pgood) ? m_pl : int'($urandom_range(3));
    reset = r; start = s; move_valid = mv; move_legal = lg;
    chk_done = cd; chk_win = cw; move_player = PW'(mp);

    prev = m_st;
    e.ack = 0; e.nack = 0; e.to = 0;
    if (r) begin
      m_st = 0;
      model_clear();
    end else if (m_st == 0 || m_st == 3) begin
      e.nack = mv;
      if (s) begin
        m_st = 1;
        model_clear();
      end
    end else if (m_st == 1) begin
      if (mv && mp == m_pl && lg) begin
        e.ack = 1; m_cnt++; m_skips = 0; m_st = 2;
      end else begin
        e.nack = mv;
        m_elapsed++;
        if (m_elapsed == TT) begin
          e.to = 1; m_elapsed = 0; m_skips++;
          if (m_skips == NP) begin
            m_st = 3; m_gs = 3;
          end else m_pl = (m_pl + 1) % NP;
        end
      end
    end else begin
      e.nack = mv;
      if (cd) begin
        if (cw) begin
          m_st = 3; m_gs = 1; m_win = m_pl;
        end else if (m_cnt == MM) begin
          m_st = 3; m_gs = 2;
        end else begin
          m_pl = (m_pl + 1) % NP; m_elapsed = 0; m_st = 1;
        end
      end
    end
    if (e.ack || e.nack || e.to || m_st != prev) begin
      e.st = m_st; e.pl = m_pl; e.cnt = m_cnt; e.win = m_win; e.gs = m_gs;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (move_ack || move_nack || turn_timeout || state != last_state)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event at %0t: ack=%0b nack=%0b to=%0b st=%0d", $time,
                 move_ack, move_nack, turn_timeout, state);
      end else begin
        e = exp_q.pop_front();
        if (move_ack !== e.ack || move_nack !== e.nack || turn_timeout !== e.to ||
            int'(state) != e.st || int'(cur_player) != e.pl || int'(move_count) != e.cnt ||
            int'(winner) != e.win || int'(game_status) != e.gs) begin
          n_bad++;
          $display("FAIL event at %0t: got ack=%0b nack=%0b to=%0b st=%0d pl=%0d cnt=%0d win=%0d gs=%0d, expected ack=%0b nack=%0b to=%0b st=%0d pl=%0d cnt=%0d win=%0d gs=%0d",
                   $time, move_ack, move_nack, turn_timeout, state, cur_player, move_count,
                   winner, game_status, e.ack, e.nack, e.to, e.st, e.pl, e.cnt, e.win, e.gs);
        end
      end
    end
    if (mon_en) last_state = state;
  end

  initial begin
    reset = 1'b1; start = 1'b0; move_valid = 1'b0; move_legal = 1'b0;
    chk_done = 1'b0; chk_win = 1'b0; move_player = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_state", int'(state), 0);
    check_val("reset_cur_player", int'(cur_player), 0);
    check_val("reset_move_count", int'(move_count), 0);
    check_val("reset_move_ack", int'(move_ack), 0);
    check_val("reset_move_nack", int'(move_nack), 0);
    check_val("reset_turn_timeout", int'(turn_timeout), 0);
    check_val("reset_winner", int'(winner), 0);
    check_val("reset_game_status", int'(game_status), 0);
    m_st = 0;
    model_clear();
    last_state = state;
    mon_en = 1'b1;

    // Fast play: mostly correct legal moves, frequent checker completion, rare wins.
    repeat (1500) drive_cycle(500, 900, 900, 600, 100, 200, 3);
    // Sparse moves so timeouts and late accepts near expiry occur.
    repeat (1500) drive_cycle(60, 800, 800, 500, 150, 100, 2);
    // No moves at all: every player times out and the game aborts.
    repeat (800) drive_cycle(0, 0, 0, 300, 0, 50, 0);
    // Mixed traffic with illegal/wrong-player requests and resets.
    repeat (1500) drive_cycle(400, 500, 600, 400, 200, 150, 10);
    repeat (40) drive_cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_val("pending_expected_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
